lia_moving_avg: RTL and testbench
=================================

Name: lia_moving_avg

Overview:
- Post-filter smoothing stage for the lock-in chain. Sits directly downstream of FIR_filter and consumes its data_out/valid stream.
- Computes a sliding boxcar mean over the last 2^lgn accepted samples using a circular sample buffer and a running sum.
- Emits one averaged sample per accepted input and feeds the magnitude/phase stage.

Parameters:
- DW, 16, sample width (signed, two's complement) for din and dout
- LG_MAX, 6, log2 of the buffer depth; maximum average length is 2^LG_MAX = 64

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  block enable; when low, inputs are ignored and all state holds
- lgn  in  4  average length select, N = 2^lgn; values above LG_MAX are clamped to LG_MAX
- din_valid  in  1  input sample strobe (FIR_filter valid)
- din  in  DW  signed input sample (FIR_filter data_out)
- busy  out  1  high while the buffer is being cleared; input samples are dropped
- dout_valid  out  1  single-cycle strobe, result on dout
- dout  out  DW  signed mean of the last N samples
- filled  out  1  high once N samples have been accepted since the last clear

Behaviour:
- Reset: dout=0, dout_valid=0, filled=0, busy=1, sum=0, wp=0, fill count=0, lgn_q=clamp(lgn); state goes to CLEAR.
- State CLEAR:
  - Writes 0 to buf[clr_idx], one entry per cycle; clr_idx runs 0..2^LG_MAX-1, so CLEAR lasts exactly 64 cycles.
  - busy=1; sum, wp and fill count are held at 0; din_valid is ignored; dout_valid=0.
  - On the last index, transition to RUN; busy goes low in the first RUN cycle.
- State RUN:
  - A sample is accepted when en & din_valid.
  - Old sample: old = buf[(wp - N) mod 2^LG_MAX], read combinationally from the register array.
  - On acceptance: buf[wp] <= din; wp <= wp+1 (wraps modulo 64); sum <= sum + din - old.
  - sum width is DW+LG_MAX (22 bits, signed), so it never overflows.
  - dout <= (sum + din - old) >>> lgn_q (arithmetic shift, floor rounding), truncated to DW. The result always fits because it is a mean of DW-bit values.
  - dout_valid <= 1 in the cycle after acceptance; latency is exactly 1 clk. dout holds its value between strobes.
  - Fill count saturates at N; filled=1 from the same cycle dout_valid reflects the Nth sample.
  - Before filled, old reads zeros, so dout = (partial sum)/N. This ramp is intended.
- Length change: in RUN, if clamp(lgn) != lgn_q, go to CLEAR.
  - lgn_q updates on entry to CLEAR; sum, wp and fill count reset to 0; filled=0.
  - Any sample presented in the detection cycle is dropped.
- en low: no acceptance, dout_valid=0, no state change. A pending CLEAR still completes, so the clear runs even with en low.
- rst in any state: overrides everything and gives the reset values above; CLEAR restarts from index 0.
- Simultaneous lgn change and din_valid: the clear wins and the sample is discarded.
- Back-to-back din_valid on every clk is supported at full rate.

Test Plan:
1. Assert rst 3 clks, release with lgn=3 -> dout=0, dout_valid=0, filled=0; busy high exactly 64 clks after release, then low.
2. lgn=3, din=800 with din_valid every 40 clks -> dout = 100, 200, ..., 700, 800 one clk after each strobe; filled rises with the 8th result; dout stays 800 after that.
3. From the steady state of test 2, step din to -800 -> results 600, 400, 200, 0, -200, -400, -600, -800, then -800 thereafter.
4. lgn=0, din=1234, then -5, then 32767 -> dout equals din 1 clk later; filled high after the first sample.
5. lgn=6, 64 samples of -32768 then 64 samples of 32767 -> dout=-32768 at the 64th result, 32767 at the 128th; no wrap or overflow anywhere. lgn=9 behaves identically to lgn=6 (clamped).
6. Mid-stream, change lgn 3->2 while din_valid pulses every clk -> busy=1 for 64 clks, no dout_valid, filled=0; then 4 samples of 400 give 100, 200, 300, 400. Repeat with rst asserted mid-CLEAR -> CLEAR restarts and busy lasts a full 64 clks after release.

Source files
------------

// File: rtl/lia_moving_avg.sv
// Sliding boxcar mean over the last 2^lgn accepted samples of the FIR output stream.
// A 64-entry circular buffer plus a running sum gives one averaged result per accepted sample.
module lia_moving_avg #(
  parameter int DW     = 16,
  parameter int LG_MAX = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [3:0]           lgn,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din,
  output logic                 busy,
  output logic                 dout_valid,
  output logic signed [DW-1:0] dout,
  output logic                 filled
);

  localparam int DEPTH = 1 << LG_MAX;
  localparam int AW    = LG_MAX;
  localparam int SW    = DW + LG_MAX;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t               state_q;
  logic signed [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]        clrIdx_q;
  logic [AW-1:0]        wp_q;
  logic [AW:0]          fillCnt_q;
  logic [3:0]           lgn_q;
  logic signed [SW-1:0] sum_q;
  logic                 busy_q;
  logic                 doutValid_q;
  logic signed [DW-1:0] dout_q;
  logic                 filled_q;

  logic [3:0]           lgnClamp;
  logic [AW:0]          nLen;
  logic [AW-1:0]        oldIdx;
  logic signed [DW-1:0] oldSample;
  logic signed [SW-1:0] sum_d;
  logic signed [DW-1:0] dout_d;
  logic [AW:0]          fillCnt_d;
  logic                 lenChange;
  logic                 accept;

  // For N = 2^LG_MAX the old index wraps onto wp itself, so the outgoing sample is read before being overwritten.
  assign lgnClamp  = (lgn > 4'(LG_MAX)) ? 4'(LG_MAX) : lgn;
  assign nLen      = (AW+1)'(1) << lgn_q;
  assign oldIdx    = wp_q - nLen[AW-1:0];
  assign oldSample = mem_q[oldIdx];
  assign lenChange = (state_q == RUN) && en && (lgnClamp != lgn_q);
  assign accept    = (state_q == RUN) && en && din_valid && !lenChange;
  assign sum_d     = sum_q + SW'(din) - SW'(oldSample);
  assign dout_d    = DW'(sum_d >>> lgn_q);
  assign fillCnt_d = (fillCnt_q == nLen) ? fillCnt_q : fillCnt_q + (AW+1)'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[clrIdx_q] <= '0;
      end else if (accept) begin
        mem_q[wp_q] <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clrIdx_q    <= '0;
      wp_q        <= '0;
      fillCnt_q   <= '0;
      lgn_q       <= lgnClamp;
      sum_q       <= '0;
      busy_q      <= 1'b1;
      doutValid_q <= 1'b0;
      dout_q      <= '0;
      filled_q    <= 1'b0;
    end else begin
      doutValid_q <= 1'b0;
      if (state_q == CLEAR) begin
        clrIdx_q <= clrIdx_q + AW'(1);
        if (clrIdx_q == AW'(DEPTH - 1)) begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      end else if (lenChange) begin
        state_q   <= CLEAR;
        clrIdx_q  <= '0;
        busy_q    <= 1'b1;
        lgn_q     <= lgnClamp;
        sum_q     <= '0;
        wp_q      <= '0;
        fillCnt_q <= '0;
        filled_q  <= 1'b0;
      end else if (accept) begin
        wp_q        <= wp_q + AW'(1);
        sum_q       <= sum_d;
        dout_q      <= dout_d;
        doutValid_q <= 1'b1;
        fillCnt_q   <= fillCnt_d;
        filled_q    <= (fillCnt_d == nLen);
      end
    end
  end

  assign busy       = busy_q;
  assign dout_valid = doutValid_q;
  assign dout       = dout_q;
  assign filled     = filled_q;

endmodule

// File: tb/tb_lia_moving_avg.sv
// Scoreboard bench for lia_moving_avg: stimulus pushes expected results, a monitor pops them on dout_valid.
module tb_lia_moving_avg;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [3:0]           lgn;
  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic                 busy;
  logic                 dout_valid;
  logic signed [DW-1:0] dout;
  logic                 filled;

  typedef struct {
    int dout;
    int filled;
    int cyc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  lia_moving_avg #(.DW(DW), .LG_MAX(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lgn        (lgn),
    .din_valid  (din_valid),
    .din        (din),
    .busy       (busy),
    .dout_valid (dout_valid),
    .dout       (dout),
    .filled     (filled)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation, one cycle after issue.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_dout_valid", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("dout", int'(dout), e.dout);
        checkOutput("filled", int'(filled), e.filled);
        checkOutput("latency", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; presents one sample for one clock, then idles for gap cycles.
  task automatic applyStimulus(input int value, input int expDout, input int expFilled, input int gap);
    exp_t e;
    din       = DW'(value);
    din_valid = 1'b1;
    e.dout    = expDout;
    e.filled  = expFilled;
    e.cyc     = cyc + 1;
    expQ.push_back(e);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic waitClear(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end while (busy && cnt < 200);
  endtask

  function automatic int floorDiv(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  initial begin
    #400000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cnt;
    int t2[10];
    int t3[9];
    int t4v[3];
    int s;
    t2  = '{100, 200, 300, 400, 500, 600, 700, 800, 800, 800};
    t3  = '{600, 400, 200, 0, -200, -400, -600, -800, -800};
    t4v = '{1234, -5, 32767};

    rst = 1'b1; en = 1'b1; lgn = 4'd3; din_valid = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_dout", int'(dout), 0);
    checkOutput("reset_dout_valid", int'(dout_valid), 0);
    checkOutput("reset_filled", int'(filled), 0);
    checkOutput("reset_busy", int'(busy), 1);
    waitClear(cnt);
    checkOutput("reset_clear_len", cnt, 64);
    checkOutput("busy_low_after_clear", int'(busy), 0);

    $display("[TB] test 2: ramp up with 800");
    for (int k = 0; k < 10; k++) applyStimulus(800, t2[k], (k >= 7) ? 1 : 0, 39);
    checkOutput("dout_hold", int'(dout), 800);

    $display("[TB] test 3: step to -800");
    for (int k = 0; k < 9; k++) applyStimulus(-800, t3[k], 1, 39);

    en = 1'b0;
    din = 16'sd1000;
    din_valid = 1'b1;
    repeat (3) @(negedge clk);
    din_valid = 1'b0;
    en = 1'b1;
    @(negedge clk);
    checkOutput("en_low_hold", int'(dout), -800);

    $display("[TB] test 4: lgn=0 passthrough");
    lgn = 4'd0;
    @(negedge clk);
    checkOutput("lgn0_busy", int'(busy), 1);
    checkOutput("lgn0_filled", int'(filled), 0);
    waitClear(cnt);
    checkOutput("lgn0_clear_len", cnt, 64);
    for (int k = 0; k < 3; k++) applyStimulus(t4v[k], t4v[k], 1, 3);

    $display("[TB] test 5: full-scale extremes at lgn=6");
    lgn = 4'd6;
    @(negedge clk);
    waitClear(cnt);
    checkOutput("lgn6_clear_len", cnt, 64);
    for (int k = 1; k <= 64; k++) applyStimulus(-32768, -512 * k, (k == 64) ? 1 : 0, 0);
    for (int j = 1; j <= 64; j++) begin
      s = -32768 * (64 - j) + 32767 * j;
      applyStimulus(32767, floorDiv(s, 64), 1, 0);
    end
    repeat (2) @(negedge clk);
    checkOutput("max_mean", int'(dout), 32767);
    lgn = 4'd9;
    @(negedge clk);
    checkOutput("lgn9_no_clear", int'(busy), 0);
    for (int j = 1; j <= 64; j++) begin
      s = 32767 * (64 - j) - 32768 * j;
      applyStimulus(-32768, floorDiv(s, 64), 1, 0);
    end
    repeat (2) @(negedge clk);
    checkOutput("min_mean", int'(dout), -32768);

    $display("[TB] test 6: length change under full-rate input");
    lgn = 4'd3;
    @(negedge clk);
    waitClear(cnt);
    for (int k = 1; k <= 4; k++) applyStimulus(400, 50 * k, 0, 0);
    din = 16'sd999;
    din_valid = 1'b1;
    lgn = 4'd2;
    @(negedge clk);
    checkOutput("chg_busy", int'(busy), 1);
    checkOutput("chg_filled", int'(filled), 0);
    waitClear(cnt);
    din_valid = 1'b0;
    checkOutput("chg_clear_len", cnt, 64);
    checkOutput("chg_filled_after", int'(filled), 0);
    for (int k = 1; k <= 4; k++) applyStimulus(400, 100 * k, (k == 4) ? 1 : 0, 0);

    lgn = 4'd1;
    repeat (20) @(negedge clk);
    checkOutput("midclear_busy", int'(busy), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("midclear_rst_busy", int'(busy), 1);
    checkOutput("midclear_rst_dout", int'(dout), 0);
    checkOutput("midclear_rst_filled", int'(filled), 0);
    waitClear(cnt);
    checkOutput("midclear_clear_len", cnt, 64);
    applyStimulus(600, 300, 0, 0);
    applyStimulus(600, 600, 1, 0);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
